// File: rtl/vnu_serial.sv
// Serial runtime-degree variable-node unit.
// Accumulates s = l + sum(r_i) one message per beat, then streams the
// extrinsic messages q_i = sat(s - r_i) with the hard decision.
module vnu_serial #(
    parameter int DATA_W = 6,
    parameter int D_MAX  = 6,
    parameter int EXT_W  = 3,
    parameter int DEG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] l,
    input  logic [DEG_W-1:0]  deg,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [DATA_W-1:0] q,
    output logic              q_last,
    output logic              dec,
    output logic              cfg_err
);
    localparam int SUM_W = DATA_W + EXT_W;

    // Symmetric saturation limits; the most negative code is never produced.
    localparam logic [DATA_W-1:0] QMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] QMIN = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t                         state, state_nxt;
    logic signed [SUM_W-1:0]        s;
    logic [DEG_W-1:0]               idx;
    logic [DEG_W-1:0]               deg_eff;
    logic [DEG_W-1:0]               last_idx;
    logic [D_MAX-1:0][DATA_W-1:0]   msg_buf;
    logic                           deg_ok;
    logic                           start_hs, r_hs, q_hs, at_last;
    logic signed [SUM_W-1:0]        diff;
    logic [DATA_W-1:0]              q_sat;

    function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] x);
        return {{EXT_W{x[DATA_W-1]}}, x};
    endfunction

    assign deg_ok   = (deg != '0) && (deg <= DEG_W'(D_MAX));
    assign last_idx = deg_eff - DEG_W'(1);
    assign at_last  = (idx == last_idx);
    assign start_hs = start_valid & start_ready;
    assign r_hs     = r_valid & r_ready;
    assign q_hs     = q_valid & q_ready;

    // Extrinsic value at full accumulator width, then symmetric clamp.
    always_comb begin
        diff  = s - sext(msg_buf[idx]);
        q_sat = diff[DATA_W-1:0];
        if (diff > sext(QMAX))
            q_sat = QMAX;
        else if (diff < sext(QMIN))
            q_sat = QMIN;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/output decode.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        r_ready     = 1'b0;
        q_valid     = 1'b0;
        q_last      = 1'b0;
        q           = '0;
        dec         = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = ACC;
            end
            ACC: begin
                r_ready = 1'b1;
                if (r_valid && at_last) state_nxt = EMIT;
            end
            EMIT: begin
                q_valid = 1'b1;
                q_last  = at_last;
                q       = q_sat;
                dec     = s[SUM_W-1];
                if (q_ready && at_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: header latch, accumulation/buffering, beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= '0;
            idx     <= '0;
            deg_eff <= DEG_W'(D_MAX);
            cfg_err <= 1'b0;
            msg_buf <= '0;
        end else begin
            if (start_hs) begin
                s       <= sext(l);
                idx     <= '0;
                deg_eff <= deg_ok ? deg : DEG_W'(D_MAX);
                cfg_err <= !deg_ok;
            end
            if (r_hs) begin
                msg_buf[idx] <= r;
                s            <= s + sext(r);
                idx          <= at_last ? '0 : idx + DEG_W'(1);
            end
            if (q_hs) begin
                idx <= at_last ? '0 : idx + DEG_W'(1);
                if (at_last) cfg_err <= 1'b0;
            end
        end
    end
endmodule
